// File: rtl/ncpu32k_lsu_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// ncpu32k_lsu_pkg - access sizes and FSM encoding for the LSU. Rev 1.0
//------------------------------------------------------------------
package ncpu32k_lsu_pkg;

  localparam int NCPU_DW = 32;
  localparam int NCPU_AW = 32;

  localparam logic [2:0] NCPU_LSU_SZ_B = 3'd0;
  localparam logic [2:0] NCPU_LSU_SZ_H = 3'd1;
  localparam logic [2:0] NCPU_LSU_SZ_W = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/ncpu32k_lsu_align.sv
`default_nettype none
//------------------------------------------------------------------
// ncpu32k_lsu_align - alignment check, store lane replication, load extract. Rev 1.0
//------------------------------------------------------------------
module ncpu32k_lsu_align
  import ncpu32k_lsu_pkg::*;
#(
  parameter int DW = NCPU_DW
) (
  input  logic [1:0]    chk_addr_i,
  input  logic [2:0]    chk_size_i,
  input  logic [DW-1:0] st_wdat_i,
  output logic          misalign_o,
  output logic [DW-1:0] st_din_o,
  input  logic [1:0]    ld_addr_i,
  input  logic [2:0]    ld_size_i,
  input  logic          ld_sext_i,
  input  logic [DW-1:0] ld_raw_i,
  output logic [DW-1:0] ld_dat_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign_o = 1'b0;
    case (chk_size_i)
      NCPU_LSU_SZ_B: misalign_o = 1'b0;
      NCPU_LSU_SZ_H: misalign_o = chk_addr_i[0];
      NCPU_LSU_SZ_W: misalign_o = |chk_addr_i;
      default:       misalign_o = 1'b1;
    endcase
  end

  // Replicate narrow store data across every lane the dcache may select.
  always_comb begin
    st_din_o = st_wdat_i;
    case (chk_size_i)
      NCPU_LSU_SZ_B: st_din_o = {(DW/8){st_wdat_i[7:0]}};
      NCPU_LSU_SZ_H: st_din_o = {(DW/16){st_wdat_i[15:0]}};
      default:       st_din_o = st_wdat_i;
    endcase
  end

  always_comb begin
    ld_byte  = ld_raw_i[{ld_addr_i, 3'b000} +: 8];
    ld_half  = ld_addr_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    ld_dat_o = ld_raw_i;
    case (ld_size_i)
      NCPU_LSU_SZ_B: ld_dat_o = {{(DW-8){ld_sext_i & ld_byte[7]}}, ld_byte};
      NCPU_LSU_SZ_H: ld_dat_o = {{(DW-16){ld_sext_i & ld_half[15]}}, ld_half};
      default:       ld_dat_o = ld_raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ncpu32k_lsu.sv
`default_nettype none
//------------------------------------------------------------------
// ncpu32k_lsu - blocking single-outstanding load/store unit in front of the dcache. Rev 1.0
//------------------------------------------------------------------
module ncpu32k_lsu
  import ncpu32k_lsu_pkg::*;
#(
  parameter int DW = NCPU_DW,
  parameter int AW = NCPU_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_in_valid,
  output logic          lsu_in_ready,
  input  logic          lsu_in_we,
  input  logic [AW-1:0] lsu_in_addr,
  input  logic [2:0]    lsu_in_size,
  input  logic          lsu_in_sext,
  input  logic [DW-1:0] lsu_in_wdat,
  input  logic [4:0]    lsu_in_rd,
  output logic          dcache_cmd_valid,
  input  logic          dcache_cmd_ready,
  output logic [AW-1:0] dcache_cmd_addr,
  output logic [2:0]    dcache_cmd_size,
  output logic          dcache_cmd_we,
  output logic [DW-1:0] dcache_din,
  input  logic          dcache_valid,
  output logic          dcache_ready,
  input  logic [DW-1:0] dcache_dout,
  output logic          lsu_wb_valid,
  input  logic          lsu_wb_ready,
  output logic          lsu_wb_we,
  output logic [4:0]    lsu_wb_rd,
  output logic [DW-1:0] lsu_wb_dat,
  output logic          lsu_exc_align,
  output logic [AW-1:0] lsu_exc_addr
);

  lsu_state_t    state_q;
  logic          in_ready_q;
  logic          we_q;
  logic          sext_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    size_q;
  logic [4:0]    rd_q;
  logic          cmd_valid_q;
  logic          dc_ready_q;
  logic [DW-1:0] din_q;
  logic          wb_valid_q;
  logic          wb_we_q;
  logic [DW-1:0] wb_dat_q;
  logic          exc_q;
  logic [AW-1:0] exc_addr_q;

  logic          misalign;
  logic [DW-1:0] st_din_d;
  logic [DW-1:0] ld_dat_d;

  // Alignment checks use the op being presented; load extraction uses the latched op.
  ncpu32k_lsu_align #(
    .DW (DW)
  ) u_align (
    .chk_addr_i (lsu_in_addr[1:0]),
    .chk_size_i (lsu_in_size),
    .st_wdat_i  (lsu_in_wdat),
    .misalign_o (misalign),
    .st_din_o   (st_din_d),
    .ld_addr_i  (addr_q[1:0]),
    .ld_size_i  (size_q),
    .ld_sext_i  (sext_q),
    .ld_raw_i   (dcache_dout),
    .ld_dat_o   (ld_dat_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      rd_q        <= '0;
      cmd_valid_q <= 1'b0;
      dc_ready_q  <= 1'b0;
      din_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_dat_q    <= '0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lsu_in_valid) begin
            in_ready_q <= 1'b0;
            we_q       <= lsu_in_we;
            sext_q     <= lsu_in_sext;
            addr_q     <= lsu_in_addr;
            size_q     <= lsu_in_size;
            rd_q       <= lsu_in_rd;
            if (misalign) begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_dat_q   <= '0;
              exc_q      <= 1'b1;
              exc_addr_q <= lsu_in_addr;
            end else begin
              state_q     <= S_CMD;
              cmd_valid_q <= 1'b1;
              din_q       <= st_din_d;
            end
          end
        end
        S_CMD: begin
          if (dcache_cmd_ready) begin
            state_q     <= S_RESP;
            cmd_valid_q <= 1'b0;
            dc_ready_q  <= 1'b1;
          end
        end
        S_RESP: begin
          if (dcache_valid) begin
            state_q    <= S_WB;
            dc_ready_q <= 1'b0;
            din_q      <= '0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= ~we_q;
            wb_dat_q   <= we_q ? '0 : ld_dat_d;
            exc_q      <= 1'b0;
          end
        end
        S_WB: begin
          if (lsu_wb_ready) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_dat_q   <= '0;
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_in_ready     = in_ready_q;
  assign dcache_cmd_valid = cmd_valid_q;
  assign dcache_cmd_addr  = addr_q;
  assign dcache_cmd_size  = size_q;
  assign dcache_cmd_we    = we_q;
  assign dcache_din       = din_q;
  assign dcache_ready     = dc_ready_q;
  assign lsu_wb_valid     = wb_valid_q;
  assign lsu_wb_we        = wb_we_q;
  assign lsu_wb_rd        = rd_q;
  assign lsu_wb_dat       = wb_dat_q;
  assign lsu_exc_align    = exc_q;
  assign lsu_exc_addr     = exc_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ncpu32k_lsu.sv
`default_nettype none
//------------------------------------------------------------------
// tb_ncpu32k_lsu - scoreboard bench for the load/store unit. Rev 1.0
//------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ncpu32k_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_in_valid = 1'b0;
  logic        lsu_in_ready;
  logic        lsu_in_we = 1'b0;
  logic [31:0] lsu_in_addr = '0;
  logic [2:0]  lsu_in_size = '0;
  logic        lsu_in_sext = 1'b0;
  logic [31:0] lsu_in_wdat = '0;
  logic [4:0]  lsu_in_rd = '0;
  logic        dcache_cmd_valid;
  logic        dcache_cmd_ready = 1'b0;
  logic [31:0] dcache_cmd_addr;
  logic [2:0]  dcache_cmd_size;
  logic        dcache_cmd_we;
  logic [31:0] dcache_din;
  logic        dcache_valid = 1'b0;
  logic        dcache_ready;
  logic [31:0] dcache_dout = '0;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready = 1'b0;
  logic        lsu_wb_we;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_dat;
  logic        lsu_exc_align;
  logic [31:0] lsu_exc_addr;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] dat;
    logic        exc;
    logic [31:0] eaddr;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  cmd_cycles = 0;

  ncpu32k_lsu #(.DW(32), .AW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_in_valid     (lsu_in_valid),
    .lsu_in_ready     (lsu_in_ready),
    .lsu_in_we        (lsu_in_we),
    .lsu_in_addr      (lsu_in_addr),
    .lsu_in_size      (lsu_in_size),
    .lsu_in_sext      (lsu_in_sext),
    .lsu_in_wdat      (lsu_in_wdat),
    .lsu_in_rd        (lsu_in_rd),
    .dcache_cmd_valid (dcache_cmd_valid),
    .dcache_cmd_ready (dcache_cmd_ready),
    .dcache_cmd_addr  (dcache_cmd_addr),
    .dcache_cmd_size  (dcache_cmd_size),
    .dcache_cmd_we    (dcache_cmd_we),
    .dcache_din       (dcache_din),
    .dcache_valid     (dcache_valid),
    .dcache_ready     (dcache_ready),
    .dcache_dout      (dcache_dout),
    .lsu_wb_valid     (lsu_wb_valid),
    .lsu_wb_ready     (lsu_wb_ready),
    .lsu_wb_we        (lsu_wb_we),
    .lsu_wb_rd        (lsu_wb_rd),
    .lsu_wb_dat       (lsu_wb_dat),
    .lsu_exc_align    (lsu_exc_align),
    .lsu_exc_addr     (lsu_exc_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dcache_cmd_valid === 1'b1) cmd_cycles++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic model_mis(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    if (sz == 3'd1) return a[0];
    if (sz == 3'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz,
                                             input logic sx, input logic [31:0] dout);
    logic [31:0] sh;
    if (sz == 3'd0) begin
      sh = dout >> (a[1:0] * 8);
      return (sx && sh[7]) ? {24'hFFFFFF, sh[7:0]} : {24'h000000, sh[7:0]};
    end
    if (sz == 3'd1) begin
      sh = dout >> (a[1] * 16);
      return (sx && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0000, sh[15:0]};
    end
    return dout;
  endfunction

  function automatic logic [31:0] model_din(input logic [2:0] sz, input logic [31:0] w);
    if (sz == 3'd0) return {4{w[7:0]}};
    if (sz == 3'd1) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic wb_t model_wb(input logic we, input logic [31:0] a, input logic [2:0] sz,
                                   input logic sx, input logic [4:0] rd, input logic [31:0] dout);
    wb_t e;
    e = '0;
    e.rd = rd;
    if (model_mis(a, sz)) begin
      e.exc   = 1'b1;
      e.eaddr = a;
    end else if (!we) begin
      e.we  = 1'b1;
      e.dat = model_load(a, sz, sx, dout);
    end
    return e;
  endfunction

  task automatic do_op(input logic we, input logic [31:0] a, input logic [2:0] sz, input logic sx,
                       input logic [31:0] wd, input logic [4:0] rd, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    while (lsu_in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin to = 1'b1; return; end
    lsu_in_valid = 1'b1; lsu_in_we = we; lsu_in_addr = a; lsu_in_size = sz;
    lsu_in_sext = sx; lsu_in_wdat = wd; lsu_in_rd = rd;
    @(posedge clk); #1;
    lsu_in_valid = 1'b0;
  endtask

  // Plays the dcache: optional command stall, then a response one cycle after acceptance.
  task automatic serve_cmd(input int stall, input logic [31:0] dout, output logic [67:0] cmd,
                           output int unst, output bit to);
    int n;
    n = 0; unst = 0; to = 1'b0; cmd = '0;
    while (dcache_cmd_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin to = 1'b1; return; end
    cmd = {dcache_cmd_addr, dcache_cmd_size, dcache_cmd_we, dcache_din};
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (dcache_cmd_valid !== 1'b1 ||
          {dcache_cmd_addr, dcache_cmd_size, dcache_cmd_we, dcache_din} !== cmd) unst++;
    end
    dcache_cmd_ready = 1'b1;
    @(posedge clk); #1;
    dcache_cmd_ready = 1'b0;
    if (dcache_ready !== 1'b1 || dcache_cmd_valid !== 1'b0 || dcache_din !== cmd[31:0]) unst++;
    dcache_valid = 1'b1; dcache_dout = dout;
    @(posedge clk); #1;
    dcache_valid = 1'b0;
  endtask

  task automatic get_wb(input int hold, output wb_t g, output int unst, output bit to);
    int  n;
    wb_t cur;
    n = 0; unst = 0; to = 1'b0; g = '0;
    while (lsu_wb_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin to = 1'b1; return; end
    g = {lsu_wb_we, lsu_wb_rd, lsu_wb_dat, lsu_exc_align, lsu_exc_addr};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cur = {lsu_wb_we, lsu_wb_rd, lsu_wb_dat, lsu_exc_align, lsu_exc_addr};
      if (lsu_wb_valid !== 1'b1 || cur !== g || lsu_in_ready !== 1'b0 ||
          dcache_cmd_valid !== 1'b0) unst++;
    end
    lsu_wb_ready = 1'b1;
    @(posedge clk); #1;
    lsu_wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_tests++;
    if (lsu_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", lsu_in_ready); end
    n_tests++;
    if ({dcache_cmd_valid, dcache_ready, lsu_wb_valid, lsu_wb_we, lsu_exc_align} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {dcache_cmd_valid, dcache_ready, lsu_wb_valid, lsu_wb_we, lsu_exc_align});
    end
    n_tests++;
    if ({lsu_wb_dat, dcache_din, lsu_exc_addr} !== 96'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {lsu_wb_dat, dcache_din, lsu_exc_addr});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({lsu_in_ready, dcache_cmd_valid, lsu_wb_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 100", {lsu_in_ready, dcache_cmd_valid, lsu_wb_valid});
    end
  endtask

  task automatic test_load(input string name, input logic [31:0] a, input logic [2:0] sz, input logic sx,
                           input logic [4:0] rd, input logic [31:0] dout);
    bit          to;
    int          unst;
    logic [67:0] cmd;
    wb_t         e, g;
    exp_q.push_back(model_wb(1'b0, a, sz, sx, rd, dout));
    do_op(1'b0, a, sz, sx, 32'hDEAD_BEEF, rd, to);
    serve_cmd(0, dout, cmd, unst, to);
    n_tests++;
    if (to || cmd[67:32] !== {a, sz, 1'b0} || unst != 0) begin
      n_fail++;
      $display("FAIL %s cmd: got addr=%h size=%0d we=%b to=%0d unst=%0d want addr=%h size=%0d we=0",
               name, cmd[67:36], cmd[35:33], cmd[32], to, unst, a, sz);
    end
    get_wb(0, g, unst, to);
    e = exp_q.pop_front();
    if (!e.exc) g.eaddr = e.eaddr;
    n_tests++;
    if (to || g !== e) begin
      n_fail++;
      $display("FAIL %s wb: got we=%b rd=%0d dat=%h exc=%b to=%0d want we=%b rd=%0d dat=%h exc=%b",
               name, g.we, g.rd, g.dat, g.exc, to, e.we, e.rd, e.dat, e.exc);
    end
  endtask

  task automatic test_misaligned(input string name, input logic we, input logic [31:0] a, input logic [2:0] sz);
    bit  to;
    int  unst, c0;
    wb_t e, g;
    c0 = cmd_cycles;
    exp_q.push_back(model_wb(we, a, sz, 1'b0, 5'd4, 32'h0));
    do_op(we, a, sz, 1'b0, 32'h1122_3344, 5'd4, to);
    get_wb(2, g, unst, to);
    e = exp_q.pop_front();
    if (!e.we) g.rd = e.rd;
    n_tests++;
    if (to || g !== e || unst != 0) begin
      n_fail++;
      $display("FAIL %s wb: got we=%b dat=%h exc=%b ea=%h to=%0d unst=%0d want we=0 dat=0 exc=1 ea=%h",
               name, g.we, g.dat, g.exc, g.eaddr, to, unst, a);
    end
    n_tests++;
    if (cmd_cycles !== c0) begin
      n_fail++; $display("FAIL %s no_cmd: got %0d cmd cycles want 0", name, cmd_cycles - c0);
    end
  endtask

  task automatic test_store_stall();
    bit          to;
    int          unst, c0;
    logic [67:0] cmd;
    wb_t         e, g;
    exp_q.push_back(model_wb(1'b1, 32'h4001, 3'd0, 1'b0, 5'd9, 32'h0));
    do_op(1'b1, 32'h4001, 3'd0, 1'b0, 32'h0000_005A, 5'd9, to);
    c0 = cmd_cycles;
    serve_cmd(3, 32'hFFFF_FFFF, cmd, unst, to);
    n_tests++;
    if (to || cmd !== {32'h4001, 3'd0, 1'b1, 32'h5A5A_5A5A}) begin
      n_fail++; $display("FAIL store_cmd: got %h want %h to=%0d", cmd, {32'h4001, 3'd0, 1'b1, 32'h5A5A_5A5A}, to);
    end
    n_tests++;
    if (unst != 0 || cmd_cycles - c0 != 4) begin
      n_fail++; $display("FAIL store_cmd_hold: got unstable=%0d valid_cycles=%0d want 0 and 4", unst, cmd_cycles - c0);
    end
    get_wb(0, g, unst, to);
    e = exp_q.pop_front();
    g.rd = e.rd;
    n_tests++;
    if (to || g !== e) begin
      n_fail++; $display("FAIL store_wb: got we=%b dat=%h exc=%b want we=0 dat=0 exc=0", g.we, g.dat, g.exc);
    end
  endtask

  task automatic test_wb_backpressure();
    bit          to;
    int          unst, c0;
    logic [67:0] cmd;
    wb_t         e, g;
    exp_q.push_back(model_wb(1'b0, 32'h5000, 3'd2, 1'b1, 5'd12, 32'h1234_5678));
    do_op(1'b0, 32'h5000, 3'd2, 1'b1, 32'h0, 5'd12, to);
    serve_cmd(0, 32'h1234_5678, cmd, unst, to);
    c0 = cmd_cycles;
    get_wb(5, g, unst, to);
    e = exp_q.pop_front();
    if (!e.exc) g.eaddr = e.eaddr;
    n_tests++;
    if (to || g !== e) begin
      n_fail++; $display("FAIL bp_wb: got dat=%h rd=%0d we=%b want dat=%h rd=%0d we=1", g.dat, g.rd, g.we, e.dat, e.rd);
    end
    n_tests++;
    if (unst != 0 || cmd_cycles != c0) begin
      n_fail++; $display("FAIL bp_hold: got unstable=%0d extra_cmd=%0d want 0 and 0", unst, cmd_cycles - c0);
    end
    n_tests++;
    if (lsu_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", lsu_in_ready); end
  endtask

  task automatic test_reset_in_resp();
    bit to;
    do_op(1'b0, 32'h6000, 3'd2, 1'b0, 32'h0, 5'd7, to);
    while (dcache_cmd_valid !== 1'b1 && !to) begin @(posedge clk); #1; end
    dcache_cmd_ready = 1'b1;
    @(posedge clk); #1;
    dcache_cmd_ready = 1'b0;
    n_tests++;
    if (dcache_ready !== 1'b1) begin n_fail++; $display("FAIL rr_in_resp: got dcache_ready=%b want 1", dcache_ready); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({dcache_cmd_valid, dcache_ready, lsu_wb_valid, lsu_in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_async: got cmd_v/dc_rdy/wb_v/in_rdy=%b want 0001",
               {dcache_cmd_valid, dcache_ready, lsu_wb_valid, lsu_in_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dcache_valid = 1'b1; dcache_dout = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dcache_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({lsu_wb_valid, lsu_in_ready, dcache_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL rr_late_resp: got wb_v/in_rdy/dc_rdy=%b want 010", {lsu_wb_valid, lsu_in_ready, dcache_ready});
    end
  endtask

  task automatic test_back_to_back();
    bit          to, to2, mis;
    int          unst, unst2;
    logic        we, sx;
    logic [31:0] a, wd, dout;
    logic [2:0]  sz;
    logic [4:0]  rd;
    logic [67:0] cmd;
    wb_t         e, g;
    for (int k = 0; k < 16; k++) begin
      we   = 1'($urandom_range(0, 1));
      sx   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 3));
      a    = 32'h7000 + 32'(k * 16) + 32'($urandom_range(0, 3));
      wd   = $urandom;
      dout = $urandom;
      rd   = 5'($urandom_range(1, 31));
      mis  = model_mis(a, sz);
      exp_q.push_back(model_wb(we, a, sz, sx, rd, dout));
      do_op(we, a, sz, sx, wd, rd, to);
      unst = 0; to2 = 1'b0;
      if (!mis) begin
        serve_cmd($urandom_range(0, 2), dout, cmd, unst, to2);
        n_tests++;
        if (to2 || unst != 0 || cmd[67:32] !== {a, sz, we} || (we && cmd[31:0] !== model_din(sz, wd))) begin
          n_fail++;
          $display("FAIL b2b_cmd[%0d]: got %h want addr=%h size=%0d we=%b din=%h", k, cmd, a, sz, we, model_din(sz, wd));
        end
      end
      get_wb($urandom_range(0, 2), g, unst2, to2);
      e = exp_q.pop_front();
      if (!e.exc) g.eaddr = e.eaddr;
      if (!e.we) g.rd = e.rd;
      n_tests++;
      if (to || to2 || g !== e || unst2 != 0 || lsu_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_wb[%0d]: got %h unst=%0d rdy=%b want %h", k, g, unst2, lsu_in_ready, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load("ld_b_sext", 32'h1003, 3'd0, 1'b1, 5'd3, 32'h80AB_CD12);
    test_load("ld_h_zext", 32'h2002, 3'd1, 1'b0, 5'd5, 32'hBEEF_1234);
    test_load("ld_h_sext", 32'h2002, 3'd1, 1'b1, 5'd6, 32'hBEEF_1234);
    test_load("ld_b_lane1", 32'h2101, 3'd0, 1'b0, 5'd8, 32'h1122_C344);
    test_misaligned("st_w_mis", 1'b1, 32'h3001, 3'd2);
    test_misaligned("sz3_mis", 1'b0, 32'h3000, 3'd3);
    test_misaligned("ld_h_mis", 1'b0, 32'h3003, 3'd1);
    test_store_stall();
    test_wb_backpressure();
    test_reset_in_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
